// File: rtl/serial_mem_responder.sv
// Memory-side responder for the CPU serial bus: decodes read/write commands on pins_in and
// answers reads on pins_out from an internal word RAM. Bus writes commit only with SERMEM_WRITE_EN.
module serial_mem_responder #(
    parameter int IO_BITS        = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int ADDR_WORD_BITS = 6,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IO_BITS-1:0]        pins_in,
    output logic [IO_BITS-1:0]        pins_out,
    output logic                      pins_oe,
    input  logic                      load_en,
    input  logic [ADDR_WORD_BITS-1:0] load_addr,
    input  logic [15:0]               load_data,
    output logic                      busy,
    output logic                      cmd_error
);

    localparam int DEPTH = 1 << ADDR_WORD_BITS;
    localparam int CW    = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
    localparam int TW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        ADDR   = 3'd2,
        TURN   = 3'd3,
        START  = 3'd4,
        RDATA  = 3'd5,
        WDATA  = 3'd6
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       tcnt;
    logic                is_write;
    logic                bad_hdr;
    logic                cnt_last;
    logic                turn_last;
    logic [15:0]         addr_sr;
    logic [15:0]         data_sr;
    logic [15:0]         tx_sr;
    logic [15:0]         addr_full;
    logic [15:0]         data_full;
    logic [15:0]         ram [0:DEPTH-1];

    // Payloads arrive LSB first, so each new chunk enters at the top of the shift register.
    assign addr_full = {pins_in, addr_sr[15:IO_BITS]};
    assign data_full = {pins_in, data_sr[15:IO_BITS]};
    assign cnt_last  = (cnt == CW'(PAYLOAD_CYCLES - 1));
    assign turn_last = (tcnt == TW'(READ_LATENCY - 1));

    always_comb begin
        state_n = state;
        bad_hdr = 1'b0;
        case (state)
            IDLE:    if (!pins_in[0]) state_n = HEADER;
            HEADER: begin
                if (pins_in == IO_BITS'(0) || pins_in == IO_BITS'(1)) begin
                    state_n = ADDR;
                end else begin
                    state_n = IDLE;
                    bad_hdr = 1'b1;
                end
            end
            ADDR:    if (cnt_last) state_n = is_write ? WDATA : TURN;
            TURN:    if (turn_last) state_n = START;
            START:   state_n = RDATA;
            RDATA:   if (cnt_last) state_n = IDLE;
            WDATA:   if (cnt_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            is_write  <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            tx_sr     <= '0;
            pins_out  <= '1;
            pins_oe   <= 1'b0;
            busy      <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_error <= bad_hdr;
            busy      <= (state_n != IDLE);
            pins_oe   <= (state_n == TURN) || (state_n == START) || (state_n == RDATA);

            if (state_n != state)                                         cnt <= '0;
            else if (state == ADDR || state == WDATA || state == RDATA)   cnt <= cnt + 1'b1;

            if (state_n != state)   tcnt <= '0;
            else if (state == TURN) tcnt <= tcnt + 1'b1;

            if (state == HEADER) is_write <= (pins_in == IO_BITS'(1));
            if (state == ADDR)   addr_sr  <= addr_full;
            if (state == WDATA)  data_sr  <= data_full;

            if (state == ADDR && cnt_last) tx_sr <= ram[addr_full[ADDR_WORD_BITS:1]];
            else if (state == RDATA)       tx_sr <= tx_sr >> IO_BITS;

            // pins_out presents the chunk for the cycle being entered; mid-RDATA that is the next chunk up.
            case (state_n)
                START:   pins_out <= '0;
                RDATA:   pins_out <= (state == RDATA) ? tx_sr[2*IO_BITS-1 -: IO_BITS]
                                                      : tx_sr[IO_BITS-1:0];
                default: pins_out <= '1;
            endcase
        end
    end

    // Backdoor loads go first so a same-index bus commit in the same cycle overrides them.
    always_ff @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
`ifdef SERMEM_WRITE_EN
        if (rst_n && state == WDATA && cnt_last) ram[addr_sr[ADDR_WORD_BITS:1]] <= data_full;
`endif
    end

endmodule

// File: tb/tb_serial_mem_responder.sv
// Bench for serial_mem_responder: table of reads plus hand-written sequences for writes,
// bad headers, aliasing, load collision and reset abort; read words checked through a scoreboard.
module tb_serial_mem_responder;

    localparam int IO  = 2;
    localparam int PC  = 8;
    localparam int AWB = 6;
    localparam int RL  = 1;
    localparam int FRAME = RL + 1 + PC;

    logic           clk;
    logic           rst_n;
    logic [IO-1:0]  pins_in;
    logic [IO-1:0]  pins_out;
    logic           pins_oe;
    logic           load_en;
    logic [AWB-1:0] load_addr;
    logic [15:0]    load_data;
    logic           busy;
    logic           cmd_error;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic        expect_abort = 1'b0;
    logic        mon_on = 1'b0;
    int          mon_cnt = 0;
    logic [15:0] mon_word;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    serial_mem_responder #(
        .IO_BITS(IO), .PAYLOAD_CYCLES(PC), .ADDR_WORD_BITS(AWB), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .cmd_error(cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic [IO-1:0] v);
        pins_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AWB-1:0] idx, input logic [15:0] d);
        load_en = 1'b1; load_addr = idx; load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [IO-1:0] hdr, input logic [15:0] addr);
        drive_cycle('0);
        drive_cycle(hdr);
        for (int k = 0; k < PC; k++) drive_cycle(addr[IO*k +: IO]);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [15:0] exp);
        exp_q.push_back(exp);
        send_cmd(2'b00, addr);
        pins_in = '1;
        chk("turn_oe", {15'd0, pins_oe}, 16'd1);
        repeat (FRAME) @(posedge clk);
        #1;
        chk("end_oe", {15'd0, pins_oe}, 16'd0);
        chk("end_busy", {15'd0, busy}, 16'd0);
    endtask

    task automatic send_write(input logic [15:0] addr, input logic [15:0] d,
                              input logic coll, input logic [15:0] cdata);
        send_cmd(2'b01, addr);
        for (int k = 0; k < PC; k++) begin
            if (coll && k == PC - 1) begin
                load_en = 1'b1; load_addr = addr[AWB:1]; load_data = cdata;
            end
            drive_cycle(d[IO*k +: IO]);
            load_en = 1'b0;
        end
        pins_in = '1;
        chk("wr_end_busy", {15'd0, busy}, 16'd0);
    endtask

    // Response monitor: idle-high turnaround, start marker, then LSB-first payload.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("err_oe_excl", {15'd0, cmd_error & pins_oe}, 16'd0);
            if (pins_oe !== 1'b1) begin
                if (mon_cnt != 0) begin
                    if (expect_abort) expect_abort = 1'b0;
                    else chk("frame_len", 16'(mon_cnt), 16'(FRAME));
                end
                mon_cnt = 0;
            end else begin
                if (mon_cnt < RL) begin
                    chk("turn_high", {14'd0, pins_out}, 16'h0003);
                end else if (mon_cnt == RL) begin
                    chk("marker", {14'd0, pins_out}, 16'h0000);
                end else if (mon_cnt < FRAME) begin
                    mon_word[IO*(mon_cnt-RL-1) +: IO] = pins_out;
                    if (mon_cnt == FRAME - 1) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_rd", mon_word, 16'hxxxx);
                        end else begin
                            chk("rd_word", mon_word, exp_q.pop_front());
                        end
                    end
                end else begin
                    chk("overlong", {15'd0, pins_oe}, 16'd0);
                end
                mon_cnt++;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_w, exp_c, ra, rd;
        logic [AWB-1:0] ri;
        rst_n = 1'b0; pins_in = '1; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pins_out", {14'd0, pins_out}, 16'h0003);
        chk("rst_oe", {15'd0, pins_oe}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_cmd_error", {15'd0, cmd_error}, 16'd0);
        rst_n = 1'b1;
        mon_on = 1'b1;
        drive_cycle('1);

        load_word(6'd2, 16'hA5C3);
        load_word(6'd62, 16'hBEEF);
        load_word(6'd0, 16'h0001);
        load_word(6'd8, 16'h0000);
        load_word(6'd16, 16'h0000);
        load_word(6'd24, 16'h0000);

        vecs[0] = '{16'h0004, 16'hA5C3};
        vecs[1] = '{16'h0005, 16'hA5C3};
        vecs[2] = '{16'hFFFC, 16'hBEEF};
        vecs[3] = '{16'h007C, 16'hBEEF};
        vecs[4] = '{16'h0084, 16'hA5C3};
        vecs[5] = '{16'h0000, 16'h0001};
        // Back-to-back: each read starts the cycle after the previous response ends.
        for (int i = 0; i < 6; i++) do_read(vecs[i].addr, vecs[i].exp);

        // Write then immediate readback; without bus writes the old word must survive.
`ifdef SERMEM_WRITE_EN
        exp_w = 16'h1234; exp_c = 16'h5555;
`else
        exp_w = 16'h0000; exp_c = 16'h7777;
`endif
        send_write(16'h0010, 16'h1234, 1'b0, 16'h0000);
        do_read(16'h0010, exp_w);
`ifdef SERMEM_WRITE_EN
        exp_w = 16'hFFFF;
`else
        exp_w = 16'h0000;
`endif
        send_write(16'h0020, 16'hFFFF, 1'b0, 16'h0000);
        do_read(16'h0020, exp_w);
        send_write(16'h0030, 16'h5555, 1'b1, 16'h7777);
        do_read(16'h0030, exp_c);

        // Bad headers pulse cmd_error for one cycle and never drive the bus.
        for (int h = 2; h < 4; h++) begin
            drive_cycle('0);
            drive_cycle(IO'(h));
            pins_in = '1;
            chk("bad_hdr_err", {15'd0, cmd_error}, 16'd1);
            chk("bad_hdr_oe", {15'd0, pins_oe}, 16'd0);
            chk("bad_hdr_busy", {15'd0, busy}, 16'd0);
            drive_cycle('1);
            chk("bad_hdr_pulse", {15'd0, cmd_error}, 16'd0);
            do_read(16'h0004, 16'hA5C3);
        end

        // Reset during the third RDATA cycle aborts the response.
        send_cmd(2'b00, 16'h007C);
        pins_in = '1;
        repeat (RL + 3) @(posedge clk);
        #1;
        chk("pre_abort_oe", {15'd0, pins_oe}, 16'd1);
        expect_abort = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_oe", {15'd0, pins_oe}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        drive_cycle('1);
        chk("abort_flag", {15'd0, expect_abort}, 16'd0);
        do_read(16'h007C, 16'hBEEF);

        // Reset during WDATA must not commit a partial word.
        send_cmd(2'b01, 16'h0010);
        for (int k = 0; k < 4; k++) drive_cycle(2'b11);
        rst_n = 1'b0;
        drive_cycle('1);
        rst_n = 1'b1;
        drive_cycle('1);
`ifdef SERMEM_WRITE_EN
        do_read(16'h0010, 16'h1234);
`else
        do_read(16'h0010, 16'h0000);
`endif

        // Random loads read back through aliased addresses.
        for (int i = 0; i < 6; i++) begin
            ri = AWB'($urandom_range(32, 61));
            rd = 16'($urandom_range(0, 65535));
            ra = {7'($urandom_range(0, 127)), 1'b0, ri, 1'($urandom_range(0, 1))};
            ra[7] = 1'($urandom_range(0, 1));
            load_word(ri, rd);
            do_read(ra, rd);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
